// File: rtl/rom_prefetch_pkg.sv
// ============================================================================
// Module      : rom_prefetch_pkg
// Description : Shared ROM bus defaults used by the ROM generator, the
//               prefetcher and the CPU fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_prefetch_pkg;

  // Default ROM bus geometry.
  localparam int unsigned ROM_ADDR_WIDTH = 9;
  localparam int unsigned ROM_DATA_WIDTH = 8;

  // First program byte fetched after reset.
  localparam int unsigned ROM_RESET_ADDR = 0;

endpackage

`default_nettype wire

// File: rtl/rom_prefetch_fifo.sv
// ============================================================================
// Module      : prefetch_fifo
// Description : Small synchronous FIFO holding prefetched {addr, data} pairs.
//               Flush overrides push and pop in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prefetch_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             w_do_pop;
  logic             w_do_push;

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign w_do_pop  = pop_i & (count_q != '0);
  assign w_do_push = push_i & ((count_q != C_FULL) | w_do_pop);

  // Pointer and occupancy tracking; flush empties the FIFO outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset because the head is gated by count.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

`default_nettype wire

// File: rtl/rom_prefetch.sv
// ============================================================================
// Module      : rom_prefetch
// Description : Sequential ROM byte prefetcher. Issues addresses to a
//               1-cycle registered ROM, buffers returned bytes and hands them
//               to the CPU over valid/ready. Jumps flush and redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_prefetch
  import rom_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ROM_DATA_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RESET_ADDR = ROM_RESET_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  rom_enable,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_addr
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] C_DEPTH = (CW + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] C_RESET_ADDR = ADDR_WIDTH'(RESET_ADDR);

  logic                  rom_enable_q;
  logic [ADDR_WIDTH-1:0] fetch_ptr_q, fetch_ptr_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;

  logic [CW-1:0]                    fifo_count;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_head;
  logic                             kill;
  logic                             fifo_push;
  logic                             fifo_pop;
  logic [CW:0]                      credit_used;
  logic                             issue;

  // A jump discards the byte returning this cycle and takes priority over pop.
  assign kill      = jump;
  assign fifo_push = inflight_q & ~kill;
  assign fifo_pop  = instr_valid & instr_ready & ~jump;

  // Redirect target bypasses the fetch pointer so it is issued in the jump cycle.
  assign rom_addr = jump ? jump_addr : fetch_ptr_q;

  // Credit check counts buffered plus returning bytes, both of which a jump clears.
  always_comb begin
    credit_used = '0;
    if (!jump) credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    issue = rom_enable_q & (credit_used < C_DEPTH);
  end

  // Next-state for the fetch pointer and the single-entry inflight tracker.
  always_comb begin
    fetch_ptr_d     = fetch_ptr_q;
    inflight_d      = issue;
    inflight_addr_d = inflight_addr_q;
    if (issue) begin
      fetch_ptr_d     = rom_addr + 1'b1;
      inflight_addr_d = rom_addr;
    end else if (jump) begin
      fetch_ptr_d = jump_addr;
    end
  end

  // Fetch state registers; enable rises once after reset and then stays high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_enable_q    <= 1'b0;
      fetch_ptr_q     <= C_RESET_ADDR;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      rom_enable_q    <= 1'b1;
      fetch_ptr_q     <= fetch_ptr_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  prefetch_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .pop_i       (fifo_pop),
    .flush_i     (jump),
    .push_data_i ({inflight_addr_q, rom_data}),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  assign rom_enable  = rom_enable_q;
  assign instr_valid = (fifo_count != '0);
  assign instr_addr  = fifo_head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign instr_data  = fifo_head[DATA_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_rom_prefetch.sv
// ============================================================================
// Module      : tb_rom_prefetch
// Description : Self-checking bench for rom_prefetch with a ROM model and a
//               stream-order reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_prefetch;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          rom_enable;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          jump;
  logic [AW-1:0] jump_addr;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_addr;

  int tests = 0;
  int fails = 0;
  int accepted = 0;

  // ROM model: registered read, output forced to zero while disabled.
  logic [DW-1:0] rom [512];
  logic [DW-1:0] rom_q = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_enable) rom_q <= rom[rom_addr];
  end
  assign rom_data = rom_enable ? rom_q : '0;

  rom_prefetch #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (4),
    .RESET_ADDR (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rom_enable  (rom_enable),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_addr  (instr_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the delivered stream is the ROM read sequentially from the
  // last redirect target (or reset address), with nothing dropped or repeated.
  logic [AW-1:0] exp_addr = '0;
  bit            inv_next = 1'b0;
  bit            hold_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_valid", instr_valid, 0);
      chk("rst_data", instr_data, 0);
      chk("rst_addr", instr_addr, 0);
      chk("rst_enable", rom_enable, 0);
      exp_addr  = '0;
      inv_next  = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (inv_next) chk("post_jump_invalid", instr_valid, 0);
      if (hold_prev) chk("hold_valid", instr_valid, 1);
      if (instr_valid) begin
        chk("stream_addr", instr_addr, exp_addr);
        chk("stream_data", instr_data, rom[exp_addr]);
      end
      if (jump) begin
        exp_addr  = jump_addr;
        inv_next  = 1'b1;
        hold_prev = 1'b0;
      end else begin
        inv_next = 1'b0;
        if (instr_valid && instr_ready) begin
          exp_addr = exp_addr + 1'b1;
          accepted++;
        end
        hold_prev = instr_valid && !instr_ready;
      end
    end
  end

  // Hard time limit so the bench always ends.
  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] hdr [4];
    hdr[0] = 8'h41; hdr[1] = 8'h53; hdr[2] = 8'h52; hdr[3] = 8'h4D;

    reset       = 1'b0;
    jump        = 1'b0;
    jump_addr   = '0;
    instr_ready = 1'b0;
    for (int i = 0; i < 512; i++) rom[i] = DW'($urandom);
    for (int i = 0; i < 4; i++) rom[i] = hdr[i];

    // Reset state
    repeat (2) step();
    chk("reset_valid", instr_valid, 0);
    chk("reset_enable", rom_enable, 0);
    chk("reset_rom_addr", rom_addr, 0);

    // 1: release with ready high, header bytes two cycles after first issue
    instr_ready = 1'b1;
    reset       = 1'b1;
    step();
    chk("t1_enable", rom_enable, 1);
    chk("t1_first_issue", rom_addr, 0);
    chk("t1_valid_c0", instr_valid, 0);
    step();
    chk("t1_valid_c1", instr_valid, 0);
    chk("t1_second_issue", rom_addr, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_valid", instr_valid, 1);
      chk("t1_addr", instr_addr, i);
      chk("t1_data", instr_data, hdr[i]);
    end

    // 2: ready low from reset fills the buffer, then drains with no gap
    reset       = 1'b0;
    instr_ready = 1'b0;
    step();
    reset = 1'b1;
    repeat (7) step();
    chk("t2_full_rom_addr", rom_addr, 4);
    chk("t2_full_valid", instr_valid, 1);
    chk("t2_full_head", instr_data, 8'h41);
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_valid", instr_valid, 1);
      chk("t2_drain_addr", instr_addr, i);
      step();
    end

    // 3: jump near the top of the space while the buffer is full
    instr_ready = 1'b0;
    repeat (6) step();
    chk("t3_full_valid", instr_valid, 1);
    jump      = 1'b1;
    jump_addr = 9'h1FE;
    #1;
    chk("t3_bypass_addr", rom_addr, 9'h1FE);
    step();
    jump        = 1'b0;
    instr_ready = 1'b1;
    chk("t3_j1_valid", instr_valid, 0);
    step();
    chk("t3_valid_1fe", instr_valid, 1);
    chk("t3_addr_1fe", instr_addr, 9'h1FE);
    step();
    chk("t3_addr_1ff", instr_addr, 9'h1FF);
    step();
    chk("t3_addr_wrap", instr_addr, 9'h000);
    chk("t3_data_wrap", instr_data, hdr[0]);

    // 4: jump while a pop is offered; jump wins
    step();
    chk("t4_valid_before", instr_valid, 1);
    jump      = 1'b1;
    jump_addr = 9'h0A0;
    step();
    jump = 1'b0;
    chk("t4_j1_valid", instr_valid, 0);
    step();
    chk("t4_target_valid", instr_valid, 1);
    chk("t4_target_addr", instr_addr, 9'h0A0);

    // 5: back-to-back jumps, only the second target survives
    jump      = 1'b1;
    jump_addr = 9'h010;
    step();
    jump_addr = 9'h020;
    step();
    jump = 1'b0;
    chk("t5_killed_first", instr_valid, 0);
    step();
    chk("t5_valid", instr_valid, 1);
    chk("t5_addr", instr_addr, 9'h020);
    step();
    chk("t5_addr_next", instr_addr, 9'h021);

    // 6: reset mid-stream with a byte in flight
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("t6_valid_async", instr_valid, 0);
    chk("t6_addr_async", instr_addr, 0);
    chk("t6_enable_async", rom_enable, 0);
    repeat (2) step();
    reset = 1'b1;
    step();
    chk("t6_restart_addr", rom_addr, 0);
    step();
    chk("t6_no_spurious", instr_valid, 0);
    step();
    chk("t6_valid", instr_valid, 1);
    chk("t6_addr", instr_addr, 0);
    chk("t6_data", instr_data, hdr[0]);

    // Randomized traffic: backpressure and jumps, checked by the stream model
    accepted = 0;
    for (int c = 0; c < 3000; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        jump = 1'b1;
        if ($urandom_range(0, 3) == 0) jump_addr = 9'h1FC + AW'($urandom_range(0, 3));
        else jump_addr = AW'($urandom);
      end else begin
        jump = 1'b0;
      end
      step();
    end
    jump = 1'b0;
    repeat (4) step();
    chk("rand_progress", (accepted > 500) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
